// File: rtl/csa_cpa_mersenne_reduce.sv
// csa_cpa_mersenne_reduce
//
// Resolves a redundant (ps, sc) carry-save pair into a binary sum, then
// reduces that sum modulo the Mersenne prime M = 2^MOD_BITS - 1.
//
// The carry-propagate add is spread over NCHUNK cycles. One CHUNK-wide
// adder handles one chunk per cycle, starting with the least significant
// chunk. The (WIDTH+1)-bit sum is then folded a fixed FOLD_CYCLES times.
// Because the fold count never changes, latency does not depend on the
// data. A final correction step maps x == M to 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   ps/sc pair is valid
//   in_ready   block can accept a pair (high only in IDLE)
//   ps, sc     carry-save operands; sc is already weighted
//   out_valid  hash word is valid (registered)
//   out_ready  consumer accepts the hash word
//   hash       (ps + sc) mod M, range 0..M-1 (registered)
//   busy       high in any state other than IDLE
//   dbg_state  current FSM state encoding, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and data stable until that edge.
// in_ready is a function of the state alone, with no path from out_ready.
module csa_cpa_mersenne_reduce #(
  parameter int WIDTH       = 192,
  parameter int CHUNK       = 48,
  parameter int MOD_BITS    = 61,
  parameter int FOLD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    ps,
  input  logic [WIDTH-1:0]    sc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MOD_BITS-1:0] hash,
  output logic                busy,
  output logic [2:0]          dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int XW     = WIDTH + 1;
  localparam int SW     = 8;

  localparam logic [XW-1:0] M_WIDE = {{(XW-MOD_BITS){1'b0}}, {MOD_BITS{1'b1}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADD  = 3'd1,
    FOLD = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ps_r;
  logic [WIDTH-1:0] sc_r;
  logic [XW-1:0]    x;
  logic             carry;
  logic [SW-1:0]    step;   // chunk index during ADD, fold index during FOLD
  logic [CHUNK:0]   chunk_sum;
  logic [XW-1:0]    fold_next;

  // The operand registers shift right by CHUNK each ADD cycle. This keeps
  // the active chunk in the low bits, so the adder has a fixed input.
  assign chunk_sum = {1'b0, ps_r[CHUNK-1:0]} + {1'b0, sc_r[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry};

  // 2^MOD_BITS == 1 (mod M), so the high part folds onto the low part.
  assign fold_next = {{(XW-MOD_BITS){1'b0}}, x[MOD_BITS-1:0]} + (x >> MOD_BITS);

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ps_r      <= '0;
      sc_r      <= '0;
      x         <= '0;
      carry     <= 1'b0;
      step      <= '0;
      hash      <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ps_r  <= ps;
            sc_r  <= sc;
            x     <= '0;
            carry <= 1'b0;
            step  <= '0;
            state <= ADD;
          end
        end

        ADD: begin
          // Each chunk result enters at the top of x[WIDTH-1:0] and moves
          // down, so after NCHUNK cycles chunk 0 sits at the LSBs.
          // x[WIDTH] ends up holding the final carry-out.
          x     <= {chunk_sum[CHUNK], chunk_sum[CHUNK-1:0], x[WIDTH-1:CHUNK]};
          carry <= chunk_sum[CHUNK];
          ps_r  <= ps_r >> CHUNK;
          sc_r  <= sc_r >> CHUNK;
          if (step == SW'(NCHUNK - 1)) begin
            step  <= '0;
            state <= FOLD;
          end else begin
            step <= step + SW'(1);
          end
        end

        FOLD: begin
          x <= fold_next;
          if (step == SW'(FOLD_CYCLES - 1)) begin
            step  <= '0;
            state <= FIX;
          end else begin
            step <= step + SW'(1);
          end
        end

        FIX: begin
          // After folding, x is at most M. M itself is the residue 0.
          hash      <= (x == M_WIDE) ? '0 : x[MOD_BITS-1:0];
          out_valid <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_cpa_mersenne_reduce.sv
// Testbench for csa_cpa_mersenne_reduce: directed vectors, a modular-
// arithmetic reference model, and a scoreboard checking every output cycle.
module tb_csa_cpa_mersenne_reduce;

  localparam int WIDTH    = 192;
  localparam int MOD_BITS = 61;
  localparam logic [MOD_BITS-1:0] M = {MOD_BITS{1'b1}};

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [WIDTH-1:0]    ps = '0;
  logic [WIDTH-1:0]    sc = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [MOD_BITS-1:0] hash;
  logic                busy;
  logic [2:0]          dbg_state;

  always #5 clk = ~clk;

  csa_cpa_mersenne_reduce dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ps        (ps),
    .sc        (sc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hash      (hash),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [MOD_BITS-1:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic logic [MOD_BITS-1:0] model(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [255:0] s;
    logic [255:0] m;
    s = 256'(a) + 256'(b);
    m = 256'(M);
    return MOD_BITS'(s % m);
  endfunction

  task automatic check(input string name, input logic [MOD_BITS-1:0] act,
                       input logic [MOD_BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_vs_ready", MOD_BITS'(busy), MOD_BITS'(!in_ready));
      if (out_valid) begin
        check("hash_not_m", MOD_BITS'(hash == M), '0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got hash %0h expected no output", hash);
        end else begin
          check("scoreboard", hash, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge. Returns just after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n;
    n = 0;
    ps = a;
    sc = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got in_ready 0 expected 1");
        break;
      end
    end
    @(posedge clk);
    exp_q.push_back(model(a, b));
    #1;
    in_valid = 1'b0;
    ps = {WIDTH{1'b1}};  // inputs are don't-care after acceptance
    sc = {WIDTH{1'b1}};
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    forever begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
      if (!busy) check("busy_while_working", MOD_BITS'(busy), MOD_BITS'(1));
      if (lat > 50) begin
        checks++;
        errors++;
        $display("FAIL out_timeout: got out_valid 0 expected 1");
        break;
      end
    end
  endtask

  task automatic run(input string name, input logic [WIDTH-1:0] a,
                     input logic [WIDTH-1:0] b, input logic [MOD_BITS-1:0] lit);
    int lat;
    send(a, b);
    wait_out(lat);
    check({name, "_latency"}, MOD_BITS'(lat), MOD_BITS'(9));
    check(name, hash, lit);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [WIDTH-1:0]    ones;
    logic [WIDTH-1:0]    one;
    logic [MOD_BITS-1:0] held;
    int lat;
    ones = {WIDTH{1'b1}};
    one  = WIDTH'(1);

    // Pin the model to hand-computed values.
    check("model_pin_full", model(ones, one), MOD_BITS'(512));
    check("model_pin_both", model(ones, ones), MOD_BITS'(1022));
    check("model_pin_small", model(WIDTH'(5), WIDTH'(7)), MOD_BITS'(12));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", MOD_BITS'(in_ready), MOD_BITS'(1));
    check("reset_out_valid", MOD_BITS'(out_valid), '0);
    check("reset_hash", hash, '0);
    check("reset_busy", MOD_BITS'(busy), '0);
    @(posedge clk);
    #1;

    run("zero", '0, '0, '0);
    run("exact_m", WIDTH'(M), '0, '0);
    run("m_plus_one", one, WIDTH'(M), MOD_BITS'(1));
    run("chunk_carry", (one << 48) - one, one, MOD_BITS'(64'h1_0000_0000_0000));
    run("carry_96", (one << 96) - one, one, MOD_BITS'(64'h8_0000_0000));
    run("carry_out", ones, one, MOD_BITS'(512));
    run("both_ones", ones, ones, MOD_BITS'(1022));

    // Backpressure: stall for 20 cycles while a new pair is offered.
    send(WIDTH'(123456789), (one << 150) + WIDTH'(77));
    wait_out(lat);
    out_ready = 1'b0;
    held = hash;
    in_valid = 1'b1;
    ps = WIDTH'(1000);
    sc = WIDTH'(2000);
    repeat (20) begin
      @(posedge clk);
      #1;
      check("stall_hash", hash, held);
      check("stall_in_ready", MOD_BITS'(in_ready), '0);
      check("stall_out_valid", MOD_BITS'(out_valid), MOD_BITS'(1));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", MOD_BITS'(in_ready), MOD_BITS'(1));
    check("release_out_valid", MOD_BITS'(out_valid), '0);
    run("after_stall", WIDTH'(1000), WIDTH'(2000), MOD_BITS'(3000));

    // Reset during ADD discards the item in flight.
    send(ones, ones);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    check("midreset_in_ready", MOD_BITS'(in_ready), MOD_BITS'(1));
    check("midreset_out_valid", MOD_BITS'(out_valid), '0);
    check("midreset_busy", MOD_BITS'(busy), '0);
    repeat (15) begin
      @(posedge clk);
      #1;
      check("midreset_no_out", MOD_BITS'(out_valid), '0);
    end
    run("post_reset", WIDTH'(5), WIDTH'(7), MOD_BITS'(12));

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", MOD_BITS'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
